rs_age: RTL

RS_AGE -- requirements
Module: rs_age

---
 rtl/rs_age_if.sv | 48 ++++
 rtl/rs_age.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rs_age_if.sv
// Reservation-station port bundle: dispatch lanes, wakeup broadcast,
// mask resolution and the issue ports.
//
// Handshake: an issue port p transfers an entry in any cycle where
// iss_valid[p] and iss_ready[p] are both high at the clock edge. iss_valid
// and iss_entry never depend on iss_ready. A port that is not accepted may
// show a different entry next cycle, because entries are ranked again by
// age every cycle. Dispatch has no ready signal. The producer must keep
// disp_count at or below free_slots.
interface rs_age_if #(
  parameter int DEPTH     = 8,
  parameter int DISP_W    = 2,
  parameter int ISSUE_W   = 2,
  parameter int CDB_W     = 2,
  parameter int PREG_BITS = 6,
  parameter int BMASK_W   = 4,
  parameter int SQ_W      = 4,
  parameter int PAYLOAD_W = 32
);
  localparam int ENTRY_W = 2 * PREG_BITS + 2 + BMASK_W + SQ_W + PAYLOAD_W;
  localparam int CNT_W   = $clog2(DISP_W + 1);
  localparam int OCC_W   = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]             disp_count;
  logic [DISP_W*ENTRY_W-1:0]    disp_entry;
  logic [CNT_W-1:0]             free_slots;
  logic [OCC_W-1:0]             occupancy;
  logic [CDB_W-1:0]             cdb_valid;
  logic [CDB_W*PREG_BITS-1:0]   cdb_tag;
  logic [SQ_W-1:0]              sq_resolve;
  logic [BMASK_W-1:0]           br_resolve;
  logic                         br_mispred;
  logic [ISSUE_W-1:0]           iss_valid;
  logic [ISSUE_W-1:0]           iss_ready;
  logic [ISSUE_W*ENTRY_W-1:0]   iss_entry;

  modport master (
    output disp_count, disp_entry, cdb_valid, cdb_tag, sq_resolve,
           br_resolve, br_mispred, iss_ready,
    input  free_slots, occupancy, iss_valid, iss_entry
  );

  modport slave (
    input  disp_count, disp_entry, cdb_valid, cdb_tag, sq_resolve,
           br_resolve, br_mispred, iss_ready,
    output free_slots, occupancy, iss_valid, iss_entry
  );
endinterface

// File: rtl/rs_age.sv
// Age-matrix reservation station. Entries wait for source tags and
// store-queue dependencies. Eligible entries are ranked oldest-first onto
// the issue ports. Resident entries are always older than new ones, and
// lower dispatch lanes are older than higher lanes in the same cycle.
module rs_age #(
  parameter int DEPTH     = 8,
  parameter int DISP_W    = 2,
  parameter int ISSUE_W   = 2,
  parameter int CDB_W     = 2,
  parameter int PREG_BITS = 6,
  parameter int BMASK_W   = 4,
  parameter int SQ_W      = 4,
  parameter int PAYLOAD_W = 32
) (
  input  logic     clock,
  input  logic     reset,
  rs_age_if.slave  bus
);
  localparam int CNT_W = $clog2(DISP_W + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW    = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

  typedef struct packed {
    logic [PREG_BITS-1:0] src1;
    logic                 src1_rdy;
    logic [PREG_BITS-1:0] src2;
    logic                 src2_rdy;
    logic [BMASK_W-1:0]   b_mask;
    logic [SQ_W-1:0]      sq_mask;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  logic [DEPTH-1:0]            valid_q;
  entry_t [DEPTH-1:0]          ent_q;
  logic [DEPTH-1:0][DEPTH-1:0] age_q;   // age_q[i][j]: entry i older than j

  entry_t [DISP_W-1:0]             disp_arr;
  logic [CDB_W-1:0][PREG_BITS-1:0] cdb_tags;
  entry_t [ISSUE_W-1:0]            iss_arr;
  logic [ISSUE_W-1:0]              iss_valid_c;

  assign disp_arr      = bus.disp_entry;
  assign cdb_tags      = bus.cdb_tag;
  assign bus.iss_entry = iss_arr;
  assign bus.iss_valid = iss_valid_c;

  function automatic entry_t clear_masks(entry_t e, logic [BMASK_W-1:0] br,
                                         logic [SQ_W-1:0] sq);
    entry_t r = e;
    r.b_mask  = e.b_mask & ~br;
    r.sq_mask = e.sq_mask & ~sq;
    return r;
  endfunction

  function automatic entry_t wake(entry_t e, logic [CDB_W-1:0] v,
                                  logic [CDB_W-1:0][PREG_BITS-1:0] t);
    entry_t r = e;
    for (int c = 0; c < CDB_W; c++) begin
      if (v[c] && e.src1 == t[c]) r.src1_rdy = 1'b1;
      if (v[c] && e.src2 == t[c]) r.src2_rdy = 1'b1;
    end
    return r;
  endfunction

  // Occupancy and dispatch headroom from registered valid bits only.
  int occ_i;
  int free_i;
  always_comb begin
    occ_i = 0;
    for (int i = 0; i < DEPTH; i++) if (valid_q[i]) occ_i++;
    free_i = (DEPTH - occ_i > DISP_W) ? DISP_W : DEPTH - occ_i;
  end
  assign bus.occupancy  = OCC_W'(occ_i);
  assign bus.free_slots = CNT_W'(free_i);

  // Squash, eligibility, and the age rank among eligible entries.
  logic [DEPTH-1:0] squash;
  logic [DEPTH-1:0] elig;
  int               rank [DEPTH];
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = valid_q[i] & bus.br_mispred & (|(ent_q[i].b_mask & bus.br_resolve));
      elig[i]   = valid_q[i] & ent_q[i].src1_rdy & ent_q[i].src2_rdy
                & ((ent_q[i].sq_mask & ~bus.sq_resolve) == '0) & ~squash[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      rank[i] = 0;
      for (int j = 0; j < DEPTH; j++) if (elig[j] && age_q[j][i]) rank[i]++;
    end
  end

  // Route the entry with rank p to port p and mark accepted ones as issued.
  logic [DEPTH-1:0] issued;
  always_comb begin
    logic [IW-1:0] p;
    iss_arr     = '0;
    iss_valid_c = '0;
    issued      = '0;
    p           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && rank[i] < ISSUE_W) begin
        p              = IW'(rank[i]);
        iss_valid_c[p] = 1'b1;
        iss_arr[p]     = clear_masks(ent_q[i], bus.br_resolve, bus.sq_resolve);
        issued[i]      = bus.iss_ready[p];
      end
    end
  end

  // Lane-ordered allocation into the lowest free slots. Same-cycle frees
  // are not reused. Lanes hit by a mispredict are dropped.
  logic [DISP_W-1:0] alloc_ok;
  logic [AW-1:0]     alloc_idx [DISP_W];
  always_comb begin
    logic [DEPTH-1:0] taken;
    logic             found;
    taken    = valid_q;
    alloc_ok = '0;
    found    = 1'b0;
    for (int k = 0; k < DISP_W; k++) begin
      alloc_idx[k] = '0;
      found        = 1'b0;
      if (k < int'(bus.disp_count) && k < free_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && !taken[i]) begin
            alloc_idx[k] = AW'(i);
            found        = 1'b1;
          end
        end
        taken[alloc_idx[k]] = 1'b1;
        alloc_ok[k] = ~(bus.br_mispred & (|(disp_arr[k].b_mask & bus.br_resolve)));
      end
    end
  end

  // Next state: retire issued or squashed entries, update masks and ready
  // bits, then write allocations and place them youngest in the age matrix.
  logic [DEPTH-1:0]            valid_d;
  entry_t [DEPTH-1:0]          ent_d;
  logic [DEPTH-1:0][DEPTH-1:0] age_d;
  always_comb begin
    logic [DEPTH-1:0] keep;
    keep    = valid_q & ~squash & ~issued;
    valid_d = keep;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = wake(clear_masks(ent_q[i], bus.br_resolve, bus.sq_resolve),
                      bus.cdb_valid, cdb_tags);
      for (int j = 0; j < DEPTH; j++) age_d[i][j] = age_q[i][j] & keep[i] & keep[j];
    end
    for (int k = 0; k < DISP_W; k++) begin
      if (alloc_ok[k]) begin
        valid_d[alloc_idx[k]] = 1'b1;
        ent_d[alloc_idx[k]]   = wake(clear_masks(disp_arr[k], bus.br_resolve, bus.sq_resolve),
                                     bus.cdb_valid, cdb_tags);
        for (int j = 0; j < DEPTH; j++) begin
          age_d[alloc_idx[k]][j] = 1'b0;
          age_d[j][alloc_idx[k]] = keep[j];
        end
        for (int m = 0; m < k; m++) if (alloc_ok[m]) age_d[alloc_idx[m]][alloc_idx[k]] = 1'b1;
      end
    end
  end

  // State registers. Reset wins over every other update.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      ent_q   <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      age_q   <= age_d;
    end
  end

  // Overfilling dispatch is a producer bug. Only the first free_slots lanes are taken.
  a_disp_fits: assert property (@(posedge clock) disable iff (reset)
                                int'(bus.disp_count) <= free_i);
endmodule
